// File: rtl/mem_io_responder_if.sv
// CPU bus plus rx/tx byte streams of the memory/IO responder.
// master = CPU and stream environment, slave = the responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        program_stop;

  modport master (
    output mem_a, mem_wr, mem_dout, rx_data, rx_valid, tx_ready,
    input  mem_din, rdy_out, rx_ready, tx_data, tx_valid, program_stop
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, rx_data, rx_valid, tx_ready,
    output mem_din, rdy_out, rx_ready, tx_data, tx_valid, program_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus a small IO window for a CPU.
// IO window (mem_a[17:16] == 2'b11):
//   0x30000 read  : pop rx byte (0x00 when empty)
//   0x30000 write : push non-zero byte into tx
//   0x30004 read  : latch cycle counter into snapshot, return byte 0
//   0x30005..7    : snapshot bytes 1..3 (no re-latch)
//   0x30004 write : push 0x00 into tx and halt the program
// rdy_out drops while tx is full or the program has halted, so no tx byte is lost.
module mem_io_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_io_responder_if.slave bus
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_BYTES = 1 << RAM_ADDR_W;

  localparam logic [17:0] IO_CHAR = 18'h30000;
  localparam logic [17:0] IO_CLK0 = 18'h30004;
  localparam logic [17:0] IO_CLK1 = 18'h30005;
  localparam logic [17:0] IO_CLK2 = 18'h30006;
  localparam logic [17:0] IO_CLK3 = 18'h30007;

  // storage
  logic [7:0] ram [RAM_BYTES];
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];

  // registered state
  logic [7:0]       ram_q_reg;
  logic [7:0]       io_q_reg;
  logic             din_from_ram_reg;
  logic [31:0]      cycle_cnt_reg;
  logic [31:0]      snapshot_reg;
  logic             program_stop_reg;
  logic [PTR_W-1:0] rx_wr_ptr_reg;
  logic [PTR_W-1:0] rx_rd_ptr_reg;
  logic [CNT_W-1:0] rx_count_reg;
  logic [PTR_W-1:0] tx_wr_ptr_reg;
  logic [PTR_W-1:0] tx_rd_ptr_reg;
  logic [CNT_W-1:0] tx_count_reg;

  // decode and handshake terms
  logic                  rdy;
  logic                  rx_full, rx_empty, tx_full, tx_empty;
  logic                  is_io, rd_access, wr_access, ram_rd, ram_wr;
  logic [17:0]           io_addr;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]            tx_push_data;
  logic                  snap_latch, stop_set;
  logic [7:0]            io_rd_data;
  logic [7:0]            snap_byte [4];
  logic                  unused_addr_bits;

  assign rx_full  = (rx_count_reg == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_count_reg == '0);
  assign tx_full  = (tx_count_reg == CNT_W'(FIFO_DEPTH));
  assign tx_empty = (tx_count_reg == '0);

  // The bus is only sampled while ready; reset forces ready low.
  assign rdy       = rst_in && !tx_full && !program_stop_reg;
  assign io_addr   = bus.mem_a[17:0];
  assign is_io     = (io_addr[17:16] == 2'b11);
  assign ram_addr  = bus.mem_a[RAM_ADDR_W-1:0];
  assign rd_access = rdy && !bus.mem_wr;
  assign wr_access = rdy && bus.mem_wr;
  assign ram_rd    = rd_access && !is_io;
  assign ram_wr    = wr_access && !is_io;

  // Upper address bits are deliberately not decoded.
  assign unused_addr_bits = ^bus.mem_a[31:18];

  // An rx pop on an empty FIFO is suppressed, so a same-cycle push just stores.
  assign rx_push      = bus.rx_valid && !rx_full;
  assign rx_pop       = rd_access && (io_addr == IO_CHAR) && !rx_empty;
  assign tx_pop       = !tx_empty && bus.tx_ready;
  assign stop_set     = wr_access && (io_addr == IO_CLK0);
  assign tx_push      = (wr_access && (io_addr == IO_CHAR) && (bus.mem_dout != 8'h00)) || stop_set;
  assign tx_push_data = stop_set ? 8'h00 : bus.mem_dout;
  assign snap_latch   = rd_access && (io_addr == IO_CLK0);

  for (genvar gi = 0; gi < 4; gi++) begin : g_snap_byte
    assign snap_byte[gi] = snapshot_reg[8*gi +: 8];
  end

  // IO read data; byte 0 of the clock comes straight from the live counter
  // because it is the value being latched on this very edge.
  always_comb begin
    io_rd_data = 8'h00;
    case (io_addr)
      IO_CHAR: io_rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
      IO_CLK0: io_rd_data = cycle_cnt_reg[7:0];
      IO_CLK1: io_rd_data = snap_byte[1];
      IO_CLK2: io_rd_data = snap_byte[2];
      IO_CLK3: io_rd_data = snap_byte[3];
      default: io_rd_data = 8'h00;
    endcase
  end

  // RAM port: write commits on the sampling edge, read is registered.
  always_ff @(posedge clk_in) begin
    if (ram_wr) ram[ram_addr] <= bus.mem_dout;
    if (ram_rd) ram_q_reg <= ram[ram_addr];
  end

  // FIFO storage writes; occupancy lives in the counters, so no reset here.
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.rx_data;
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= tx_push_data;
  end

  // Control state: read-result select, counter, snapshot, halt flag, FIFO pointers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      io_q_reg         <= 8'h00;
      din_from_ram_reg <= 1'b0;
      cycle_cnt_reg    <= 32'h0;
      snapshot_reg     <= 32'h0;
      program_stop_reg <= 1'b0;
      rx_wr_ptr_reg    <= '0;
      rx_rd_ptr_reg    <= '0;
      rx_count_reg     <= '0;
      tx_wr_ptr_reg    <= '0;
      tx_rd_ptr_reg    <= '0;
      tx_count_reg     <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;

      if (rd_access) begin
        din_from_ram_reg <= !is_io;
        if (is_io) io_q_reg <= io_rd_data;
      end

      if (snap_latch) snapshot_reg <= cycle_cnt_reg;
      if (stop_set) program_stop_reg <= 1'b1;

      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count_reg <= rx_count_reg + CNT_W'(1);
        2'b01:   rx_count_reg <= rx_count_reg - CNT_W'(1);
        default: ;
      endcase

      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_W'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count_reg <= tx_count_reg + CNT_W'(1);
        2'b01:   tx_count_reg <= tx_count_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.mem_din      = din_from_ram_reg ? ram_q_reg : io_q_reg;
  assign bus.rdy_out      = rdy;
  assign bus.rx_ready     = !rx_full;
  assign bus.tx_valid     = !tx_empty;
  assign bus.tx_data      = tx_mem[tx_rd_ptr_reg];
  assign bus.program_stop = program_stop_reg;

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue/array reference model.
module tb_mem_io_responder;
  localparam int RAM_ADDR_W = 17;
  localparam int FIFO_DEPTH = 8;
  localparam int RAM_MASK   = (1 << RAM_ADDR_W) - 1;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_ADDR_W(RAM_ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int check_count = 0;
  int pass_count  = 0;

  // reference model
  logic [7:0]  ram_m [int];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  tx_log[$];
  logic [31:0] cnt_m  = 0;
  logic [31:0] snap_m = 0;
  logic [7:0]  din_m  = 0;
  bit          din_known = 0;
  bit          stop_m = 0;
  bit          checking = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit rdy_m();
    return rst_in && (tx_q.size() < FIFO_DEPTH) && !stop_m;
  endfunction

  // One clock: check combinational outputs, apply the edge to the model,
  // then check registered outputs just after the edge.
  task automatic cycle();
    bit          acc, rx_acc, tx_pop, wr;
    logic [31:0] a;
    logic [17:0] ia;
    logic [7:0]  dout, rxd;
    int          idx;
    #2;
    if (checking) begin
      check_eq("rdy_out", bus.rdy_out, rdy_m());
      check_eq("rx_ready", bus.rx_ready, rx_q.size() < FIFO_DEPTH);
      check_eq("tx_valid", bus.tx_valid, tx_q.size() != 0);
      if (tx_q.size() != 0) check_eq("tx_data", bus.tx_data, tx_q[0]);
    end
    acc    = rdy_m();
    a      = bus.mem_a;
    ia     = a[17:0];
    wr     = bus.mem_wr;
    dout   = bus.mem_dout;
    rxd    = bus.rx_data;
    rx_acc = bus.rx_valid && (rx_q.size() < FIFO_DEPTH);
    tx_pop = (tx_q.size() != 0) && bus.tx_ready;
    if (tx_pop) tx_log.push_back(bus.tx_data);
    if (acc) $display("[%0t] access a=0x%08h wr=%0d dout=0x%02h", $time, a, wr, dout);
    @(posedge clk_in);
    if (!rst_in) begin
      rx_q.delete();
      tx_q.delete();
      cnt_m = 0; snap_m = 0; din_m = 0; din_known = 1; stop_m = 0;
    end else begin
      if (tx_pop) void'(tx_q.pop_front());
      if (acc) begin
        if (ia[17:16] == 2'b11) begin
          if (!wr) begin
            din_known = 1;
            case (ia)
              18'h30000: din_m = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
              18'h30004: begin snap_m = cnt_m; din_m = cnt_m[7:0]; end
              18'h30005: din_m = snap_m[15:8];
              18'h30006: din_m = snap_m[23:16];
              18'h30007: din_m = snap_m[31:24];
              default:   din_m = 8'h00;
            endcase
          end else if (ia == 18'h30000 && dout != 8'h00) begin
            tx_q.push_back(dout);
          end else if (ia == 18'h30004) begin
            tx_q.push_back(8'h00);
            stop_m = 1;
          end
        end else begin
          idx = int'(a) & RAM_MASK;
          if (wr) ram_m[idx] = dout;
          else if (ram_m.exists(idx)) begin din_m = ram_m[idx]; din_known = 1; end
          else din_known = 0;
        end
      end
      if (rx_acc) rx_q.push_back(rxd);
      cnt_m = cnt_m + 1;
    end
    #1;
    if (checking) begin
      if (din_known) check_eq("mem_din", bus.mem_din, din_m);
      check_eq("program_stop", bus.program_stop, stop_m);
    end
  endtask

  task automatic acc_op(input logic [31:0] a, input logic w, input logic [7:0] d);
    bus.mem_a = a; bus.mem_wr = w; bus.mem_dout = d;
    cycle();
  endtask

  task automatic idle();
    acc_op(32'h0003_000C, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] n, word;
    bus.mem_a = 0; bus.mem_wr = 0; bus.mem_dout = 0;
    bus.rx_data = 0; bus.rx_valid = 0; bus.tx_ready = 1;

    // reset and first cycle after release
    cycle(); cycle();
    checking = 1;
    cycle();
    check_eq("rst_mem_din", bus.mem_din, 8'h00);
    check_eq("rst_tx_valid", bus.tx_valid, 1'b0);
    check_eq("rst_stop", bus.program_stop, 1'b0);
    check_eq("rst_rdy", bus.rdy_out, 1'b0);
    rst_in = 1;
    #1 check_eq("rdy_first", bus.rdy_out, 1'b1);

    // RAM write then read-back
    acc_op(32'h0000_0010, 1'b1, 8'hA5);
    acc_op(32'h0000_0010, 1'b0, 8'h00);
    check_eq("ram_rd_a5", bus.mem_din, 8'hA5);

    // rx bytes popped in order, then empty
    bus.rx_valid = 1; bus.rx_data = 8'h41; idle();
    bus.rx_data = 8'h42; idle();
    bus.rx_valid = 0;
    acc_op(32'h0003_0000, 1'b0, 8'h00); check_eq("rx_pop1", bus.mem_din, 8'h41);
    acc_op(32'h0003_0000, 1'b0, 8'h00); check_eq("rx_pop2", bus.mem_din, 8'h42);
    acc_op(32'h0003_0000, 1'b0, 8'h00); check_eq("rx_pop3", bus.mem_din, 8'h00);

    // push and pop together on an empty rx FIFO
    bus.rx_valid = 1; bus.rx_data = 8'h55;
    acc_op(32'h0003_0000, 1'b0, 8'h00); check_eq("rx_simul_empty", bus.mem_din, 8'h00);
    bus.rx_valid = 0;
    acc_op(32'h0003_0000, 1'b0, 8'h00); check_eq("rx_simul_kept", bus.mem_din, 8'h55);

    // fill tx while blocked, then drain in order
    tx_log.delete();
    bus.tx_ready = 0;
    for (int i = 0; i < 8; i++) acc_op(32'h0003_0000, 1'b1, 8'h10 + 8'(i));
    check_eq("tx_full_rdy", bus.rdy_out, 1'b0);
    idle();
    bus.tx_ready = 1;
    for (int i = 0; i < 20 && tx_q.size() != 0; i++) idle();
    check_eq("drain_valid", bus.tx_valid, 1'b0);
    check_eq("tx_log_n", tx_log.size(), 8);
    for (int i = 0; i < 8 && i < tx_log.size(); i++) check_eq("tx_order", tx_log[i], 8'h10 + 8'(i));
    check_eq("rdy_back", bus.rdy_out, 1'b1);

    // cycle-counter snapshot read with irregular spacing
    repeat (5) idle();
    acc_op(32'h0003_0004, 1'b0, 8'h00);
    n = snap_m;
    word = 0;
    word[7:0] = bus.mem_din;
    for (int k = 1; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) acc_op(32'h0000_0200 + k, 1'b1, 8'h5A);
      acc_op(32'h0003_0004 + k, 1'b0, 8'h00);
      word[8*k +: 8] = bus.mem_din;
    end
    check_eq("snap_word", word, n);

    // zero write ignored, then stop
    bus.tx_ready = 0;
    acc_op(32'h0003_0000, 1'b1, 8'h00);
    check_eq("zero_ignored", bus.tx_valid, 1'b0);
    acc_op(32'h0003_0004, 1'b1, 8'h77);
    check_eq("stop_tx_valid", bus.tx_valid, 1'b1);
    check_eq("stop_tx_data", bus.tx_data, 8'h00);
    check_eq("stop_flag", bus.program_stop, 1'b1);
    check_eq("stop_rdy", bus.rdy_out, 1'b0);
    bus.tx_ready = 1;
    idle();
    check_eq("stop_drained", bus.tx_valid, 1'b0);
    check_eq("stop_sticky", bus.program_stop, 1'b1);

    // reset mid-operation with bytes queued
    rst_in = 0; idle(); rst_in = 1;
    bus.tx_ready = 0;
    for (int i = 0; i < 3; i++) acc_op(32'h0003_0000, 1'b1, 8'hC0 + 8'(i));
    acc_op(32'h0003_0004, 1'b1, 8'h00);
    rst_in = 0; idle();
    check_eq("rst2_tx_valid", bus.tx_valid, 1'b0);
    check_eq("rst2_stop", bus.program_stop, 1'b0);
    check_eq("rst2_din", bus.mem_din, 8'h00);
    rst_in = 1;
    #1 check_eq("rst2_rdy", bus.rdy_out, 1'b1);

    // random traffic
    bus.tx_ready = 1;
    for (int s = 0; s < 3; s++)
      for (int l = 0; l < 16; l++)
        acc_op((s << 16) | (32'h100 + l * 8), 1'b1, 8'($urandom));
    for (int c = 0; c < 3000; c++) begin
      int r, seg;
      logic [31:0] hi, lo;
      r   = $urandom_range(0, 99);
      seg = $urandom_range(0, 2);
      hi  = $urandom & 32'hFFFC_0000;
      lo  = 32'h100 + $urandom_range(0, 15) * 8;
      bus.rx_valid = $urandom_range(0, 1);
      bus.rx_data  = 8'($urandom);
      bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (r < 25)      acc_op(hi | (seg << 16) | lo, 1'b1, 8'($urandom));
      else if (r < 50) acc_op(hi | (seg << 16) | lo, 1'b0, 8'h00);
      else if (r < 65) acc_op(hi | 32'h3_0000, 1'b0, 8'h00);
      else if (r < 80) acc_op(hi | 32'h3_0000, 1'b1, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      else if (r < 90) acc_op(hi | 32'h3_0004 | $urandom_range(0, 3), 1'b0, 8'h00);
      else acc_op(hi | 32'h3_0000 | $urandom_range(8, 16'hFFFF), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_W, default 17, giving the RAM byte-address width (128 KB).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, giving the rx/tx FIFO depth, a power of two and at least 2.
REQ-003 SHALL have clk_in  in  1  the only clock; all logic is on the rising edge.
REQ-004 SHALL have rst_in  in  1  synchronous, active-low reset.
REQ-005 SHALL have mem_a  in  32  CPU address bus; only bits 17:0 are decoded.
REQ-006 SHALL have mem_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have mem_dout  in  8  CPU write data.
REQ-008 SHALL have mem_din  out  8  read data to the CPU, registered.
REQ-009 SHALL have rdy_out  out  1  CPU ready; while low, the CPU freezes and this block ignores the bus.
REQ-010 SHALL have rx_data  in  8, rx_valid  in  1, rx_ready  out  1  input-byte stream (valid/ready).
REQ-011 SHALL have tx_data  out  8, tx_valid  out  1, tx_ready  in  1  output-byte stream (valid/ready).
REQ-012 SHALL have program_stop  out  1  sticky program-halt flag.

Function
REQ-013 SHALL sample a bus access only on edges where rdy_out=1; one access per cycle.
REQ-014 SHALL decode IO space as mem_a[17:16]==2'b11; all other addresses access RAM at mem_a[RAM_ADDR_W-1:0], wrapping modulo the RAM size.
REQ-015 SHALL, for a RAM read, return the byte on mem_din exactly one cycle after the address is sampled.
REQ-016 SHALL commit a RAM write on the sampling edge, so a read of the same address in the next cycle returns the new byte.
REQ-017 SHALL, for an IO read of 0x30000, pop the rx FIFO and drive the popped byte on mem_din the next cycle; if the FIFO is empty, it returns 0x00 and pops nothing.
REQ-018 SHALL, for an IO read of 0x30004, latch the current 32-bit cycle counter into a snapshot and return snapshot[7:0] the next cycle.
REQ-019 SHALL return snapshot bytes [15:8], [23:16] and [31:24] for reads of 0x30005, 0x30006 and 0x30007; these reads do not re-latch the snapshot.
REQ-020 SHALL increment the cycle counter every clock after reset, including while rdy_out=0, and wrap from 0xFFFFFFFF to 0.
REQ-021 SHALL, for an IO write to 0x30000 with mem_dout != 0, push mem_dout into the tx FIFO; a write of 0x00 is ignored.
REQ-022 SHALL, for an IO write to 0x30004, push 0x00 into the tx FIFO and set program_stop=1 on the next cycle.
REQ-023 SHALL, for any other IO address, return 0x00 on a read and ignore a write.
REQ-024 SHALL drive rdy_out = rst_in && !tx_full && !program_stop.
REQ-025 SHALL never lose a tx byte, since rdy_out=0 whenever the tx FIFO is full.
REQ-026 SHALL drive rx_ready = !rx_full and push rx_data when rx_valid && rx_ready.
REQ-027 SHALL, on a simultaneous rx push and pop while the FIFO is empty, return 0x00 and store the pushed byte.
REQ-028 SHALL, on a simultaneous rx push and pop while the FIFO is full, leave the pushed byte unaccepted, because rx_ready=0.
REQ-029 SHALL drive tx_valid = !tx_empty and tx_data = head of the tx FIFO; the head is popped on tx_valid && tx_ready.
REQ-030 SHALL handle a simultaneous tx push and pop at any fill level, keeping the count unchanged.
REQ-031 SHALL hold mem_din at its last value on cycles with no read.
REQ-032 SHALL keep program_stop=1 until reset; the tx FIFO continues draining after program_stop is set.

Reset
REQ-033 SHALL, while rst_in=0 at an edge, empty both FIFOs and clear to 0 the counter, snapshot, mem_din, tx_valid and program_stop.
REQ-034 SHALL drive rdy_out=0 during reset and rdy_out=1 on the first cycle after reset deasserts.
REQ-035 SHALL not reset RAM contents.
REQ-036 SHALL, if reset is asserted mid-operation, discard pending tx bytes and any in-flight read result.

Verification
REQ-037 SHALL cover: write 0xA5 to 0x00010, then read 0x00010 the next cycle -> mem_din=0xA5 one cycle after the read.
REQ-038 SHALL cover: push rx bytes 0x41 and 0x42, then read 0x30000 three times -> mem_din 0x41, 0x42, 0x00.
REQ-039 SHALL cover: hold tx_ready=0 and write 8 non-zero bytes to 0x30000 -> rdy_out=0 after the 8th; then tx_ready=1 -> bytes appear in order and rdy_out returns to 1.
REQ-040 SHALL cover: write 0x00 to 0x30000 -> no tx byte; then write to 0x30004 -> tx byte 0x00, program_stop=1, rdy_out=0.
REQ-041 SHALL cover: read 0x30004 at counter value N, then 0x30005..0x30007 -> the four bytes of N, little-endian, independent of the read spacing.
REQ-042 SHALL cover: rst_in=0 with 3 bytes queued in tx -> tx_valid=0, program_stop=0, and rdy_out=1 after release.
